// File: rtl/nzr_bit_gen.sv
// nzr_bit_gen: WS2812B single-wire bit encoder.
// Turns one qmode code per bit period into a timed high/low pulse.
module nzr_bit_gen #(
  parameter int BIT_CLKS = 128,
  parameter int T0H_CLKS = 40,
  parameter int T1H_CLKS = 80,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] qmode,
  input  logic       StartCoding,
  output logic       bdone,
  output logic       Dout,
  output logic       busy,
  output logic       err
);

  typedef enum logic {
    RST = 1'b0,
    BIT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] TH0  = CW'(T0H_CLKS);
  localparam logic [CW-1:0] TH1  = CW'(T1H_CLKS);

  state_t          r_state;
  state_t          w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nx;
  logic            r_bitval;
  logic            w_bitval_nx;
  logic            r_dout;
  logic            w_dout_nx;
  logic            r_err;
  logic            w_err_nx;
  logic [CW-1:0]   w_th;
  logic            w_last;

  assign w_th   = r_bitval ? TH1 : TH0;
  assign w_last = (r_state == BIT) && (r_cnt == LAST);

  // State, counter and registered line output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RST;
      r_cnt    <= '0;
      r_bitval <= 1'b0;
      r_dout   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_bitval <= w_bitval_nx;
      r_dout   <= w_dout_nx;
      r_err    <= w_err_nx;
    end
  end

  // Next state: restart wins, then idle hold, sample, wrap, count.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_bitval_nx = r_bitval;
    w_dout_nx   = 1'b0;
    w_err_nx    = r_err;
    if (StartCoding) begin
      w_state_nx = BIT;
      w_cnt_nx   = '0;
    end else if (r_state == RST) begin
      w_cnt_nx = '0;
    end else if (r_cnt == '0) begin
      if (qmode[1]) begin
        w_state_nx = RST;
        if (qmode[0]) begin
          w_err_nx = 1'b1;
        end
      end else begin
        w_bitval_nx = qmode[0];
        w_cnt_nx    = CW'(1);
        w_dout_nx   = 1'b1;
      end
    end else if (r_cnt == LAST) begin
      w_cnt_nx = '0;
    end else begin
      w_cnt_nx  = r_cnt + CW'(1);
      w_dout_nx = (r_cnt < w_th);
    end
  end

  assign bdone = w_last && !StartCoding;
  assign busy  = (r_state == BIT);
  assign Dout  = r_dout;
  assign err   = r_err;

endmodule

// File: tb/tb_nzr_bit_gen.sv
// tb_nzr_bit_gen: directed bench for the WS2812B bit encoder.
// Records per-cycle traces and checks pulse widths and bdone timing.
module tb_nzr_bit_gen;

  logic       clk;
  logic       reset;
  logic [1:0] qmode;
  logic       StartCoding;
  logic       bdone;
  logic       Dout;
  logic       busy;
  logic       err;

  int checks;
  int errors;

  bit t_dout  [0:4095];
  bit t_bdone [0:4095];
  bit t_busy  [0:4095];

  int q_w[$];
  int q_s[$];
  int q_b[$];

  nzr_bit_gen dut (
    .clk        (clk),
    .reset      (reset),
    .qmode      (qmode),
    .StartCoding(StartCoding),
    .bdone      (bdone),
    .Dout       (Dout),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ends at posedge+1 of the first sample cycle (S+1).
  task automatic start_pulse();
    @(posedge clk);
    #1;
    StartCoding = 1'b1;
    @(posedge clk);
    #1;
    StartCoding = 1'b0;
  endtask

  // Behavioural GRB upstream: one qmode per bit, advance after bdone,
  // 10 after the last bit. Trace index k is cycle S+k.
  task automatic record(input logic [23:0] pat, input int nbits,
                        input int ncyc);
    int idx;
    idx = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (idx < nbits) qmode = {1'b0, pat[5'(nbits - 1 - idx)]};
      else qmode = 2'b10;
      @(negedge clk);
      t_dout[k]  = Dout;
      t_bdone[k] = bdone;
      t_busy[k]  = busy;
      if (bdone) idx++;
      @(posedge clk);
      #1;
    end
  endtask

  // Extract high-pulse widths/starts and bdone cycles from the trace.
  task automatic decode(input int ncyc);
    int run;
    q_w.delete();
    q_s.delete();
    q_b.delete();
    run = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (t_dout[k]) begin
        if (run == 0) q_s.push_back(k);
        run++;
      end else if (run != 0) begin
        q_w.push_back(run);
        run = 0;
      end
      if (t_bdone[k]) q_b.push_back(k);
    end
    if (run != 0) q_w.push_back(run);
  endtask

  task automatic test_reset();
    int bad;
    #1;
    checks++;
    if (Dout !== 1'b0) begin
      errors++;
      $display("FAIL rst_dout got %b want 0", Dout);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    checks++;
    if (bdone !== 1'b0) begin
      errors++;
      $display("FAIL rst_bdone got %b want 0", bdone);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got %b want 0", err);
    end
    @(negedge clk);
    reset = 1'b1;
    qmode = 2'b01;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || Dout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_after_rst got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_one_bit();
    qmode = 2'b01;
    start_pulse();
    record(24'h1, 1, 140);
    decode(140);
    checks++;
    if (q_w.size() != 1) begin
      errors++;
      $display("FAIL one_npulse got %0d want 1", q_w.size());
    end else begin
      checks++;
      if (q_w[0] != 80) begin
        errors++;
        $display("FAIL one_width got %0d want 80", q_w[0]);
      end
      checks++;
      if (q_s[0] != 2) begin
        errors++;
        $display("FAIL one_rise got %0d want 2", q_s[0]);
      end
    end
    checks++;
    if (q_b.size() != 1) begin
      errors++;
      $display("FAIL one_nbdone got %0d want 1", q_b.size());
    end else begin
      checks++;
      if (q_b[0] != 128) begin
        errors++;
        $display("FAIL one_bdone_at got %0d want 128", q_b[0]);
      end
    end
    checks++;
    if (t_busy[129] !== 1'b1) begin
      errors++;
      $display("FAIL one_busy129 got %b want 1", t_busy[129]);
    end
    checks++;
    if (t_busy[130] !== 1'b0) begin
      errors++;
      $display("FAIL one_busy130 got %b want 0", t_busy[130]);
    end
    checks++;
    if (t_dout[140] !== 1'b0) begin
      errors++;
      $display("FAIL one_idle_dout got %b want 0", t_dout[140]);
    end
  endtask

  task automatic test_zero_bit();
    qmode = 2'b00;
    start_pulse();
    record(24'h0, 1, 140);
    decode(140);
    checks++;
    if (q_w.size() != 1) begin
      errors++;
      $display("FAIL zero_npulse got %0d want 1", q_w.size());
    end else begin
      checks++;
      if (q_w[0] != 40) begin
        errors++;
        $display("FAIL zero_width got %0d want 40", q_w[0]);
      end
    end
    checks++;
    if (q_b.size() != 1) begin
      errors++;
      $display("FAIL zero_nbdone got %0d want 1", q_b.size());
    end else begin
      checks++;
      if (q_b[0] != 128) begin
        errors++;
        $display("FAIL zero_bdone_at got %0d want 128", q_b[0]);
      end
    end
  endtask

  task automatic test_frame();
    logic [23:0] pat;
    int exp_w;
    pat = 24'hA50F3C;
    start_pulse();
    record(pat, 24, 3080);
    decode(3080);
    checks++;
    if (q_w.size() != 24) begin
      errors++;
      $display("FAIL frm_npulse got %0d want 24", q_w.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        exp_w = pat[5'(23 - i)] ? 80 : 40;
        checks++;
        if (q_w[i] != exp_w) begin
          errors++;
          $display("FAIL frm_width[%0d] got %0d want %0d",
                   i, q_w[i], exp_w);
        end
        checks++;
        if (q_s[i] != 2 + 128 * i) begin
          errors++;
          $display("FAIL frm_rise[%0d] got %0d want %0d",
                   i, q_s[i], 2 + 128 * i);
        end
      end
    end
    checks++;
    if (q_b.size() != 24) begin
      errors++;
      $display("FAIL frm_nbdone got %0d want 24", q_b.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (q_b[i] != 128 * (i + 1)) begin
          errors++;
          $display("FAIL frm_bdone[%0d] got %0d want %0d",
                   i, q_b[i], 128 * (i + 1));
        end
      end
    end
    checks++;
    if (t_busy[3073] !== 1'b1) begin
      errors++;
      $display("FAIL frm_busy3073 got %b want 1", t_busy[3073]);
    end
    checks++;
    if (t_busy[3074] !== 1'b0) begin
      errors++;
      $display("FAIL frm_busy3074 got %b want 0", t_busy[3074]);
    end
  endtask

  task automatic test_restart();
    int nb;
    qmode = 2'b01;
    start_pulse();
    nb = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bdone) nb++;
      step();
    end
    StartCoding = 1'b1;
    @(negedge clk);
    if (bdone) nb++;
    checks++;
    if (Dout !== 1'b1) begin
      errors++;
      $display("FAIL rs_mid_dout got %b want 1", Dout);
    end
    step();
    StartCoding = 1'b0;
    record(24'h1, 1, 140);
    decode(140);
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL rs_abort_bdone got %0d want 0", nb);
    end
    checks++;
    if (t_dout[1] !== 1'b0) begin
      errors++;
      $display("FAIL rs_gap got %b want 0", t_dout[1]);
    end
    checks++;
    if (q_w.size() != 1) begin
      errors++;
      $display("FAIL rs_npulse got %0d want 1", q_w.size());
    end else begin
      checks++;
      if (q_w[0] != 80 || q_s[0] != 2) begin
        errors++;
        $display("FAIL rs_pulse got w%0d@%0d want w80@2",
                 q_w[0], q_s[0]);
      end
    end
    checks++;
    if (q_b.size() != 1) begin
      errors++;
      $display("FAIL rs_nbdone got %0d want 1", q_b.size());
    end else begin
      checks++;
      if (q_b[0] != 128) begin
        errors++;
        $display("FAIL rs_bdone_at got %0d want 128", q_b[0]);
      end
    end
  endtask

  task automatic test_illegal();
    qmode = 2'b11;
    start_pulse();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL ill_sample got busy%b err%b want busy1 err0",
               busy, err);
    end
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ill_busy got %b want 0", busy);
    end
    checks++;
    if (Dout !== 1'b0) begin
      errors++;
      $display("FAIL ill_dout got %b want 0", Dout);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL ill_err got %b want 1", err);
    end
    start_pulse();
    record(24'h0, 1, 140);
    decode(140);
    checks++;
    if (q_w.size() != 1) begin
      errors++;
      $display("FAIL ill_frame_npulse got %0d want 1", q_w.size());
    end else begin
      checks++;
      if (q_w[0] != 40) begin
        errors++;
        $display("FAIL ill_frame_width got %0d want 40", q_w[0]);
      end
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL ill_err_sticky got %b want 1", err);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    qmode = 2'b01;
    start_pulse();
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    checks++;
    if (Dout !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre got dout%b busy%b want 1 1", Dout, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (Dout !== 1'b0) begin
      errors++;
      $display("FAIL ar_dout got %b want 0", Dout);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ar_busy got %b want 0", busy);
    end
    checks++;
    if (bdone !== 1'b0) begin
      errors++;
      $display("FAIL ar_bdone got %b want 0", bdone);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL ar_err got %b want 0", err);
    end
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || Dout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ar_idle got %0d bad cycles want 0", bad);
    end
    start_pulse();
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || Dout !== 1'b1) begin
      errors++;
      $display("FAIL ar_restart got busy%b dout%b want 1 1",
               busy, Dout);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    qmode       = 2'b00;
    StartCoding = 1'b0;
    test_reset();
    test_one_bit();
    test_zero_bit();
    test_frame();
    test_restart();
    test_illegal();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nzr_bit_gen.md
# nzr_bit_gen

Non-return-to-zero bit encoder for the WS2812B LED chain. It sits directly downstream of the GRB shipping state machine and consumes that machine's `qmode` and `StartCoding`. It produces the single-wire serial waveform `Dout` and the per-bit `bdone` tick that the state machine uses to shift its pattern and advance its bit counter. The design runs at 100 MHz (10 ns per tick); the bit period is 1.28 µs.

## Interface
- `BIT_CLKS`, 128: bit period in clocks.
- `T0H_CLKS`, 40: high time for a 0 bit.
- `T1H_CLKS`, 80: high time for a 1 bit.
- `CW`, 8: counter width.
- Legal parameter range: 0 < `T0H_CLKS` < `T1H_CLKS` < `BIT_CLKS` ≤ 2^`CW`.

Ports:
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `qmode` in 2: code selector: 00 = send 0, 01 = send 1, 10 = RESET (line low), 11 = illegal.
- `StartCoding` in 1: one-cycle pulse that starts bit coding from a clean bit boundary.
- `bdone` out 1: one-cycle pulse on the last clock of every coded bit period.
- `Dout` out 1: serial data to the LED chain. Registered.
- `busy` out 1: high while in state BIT.
- `err` out 1: sticky flag, set when `qmode`=11 is sampled.

## Operation
- States:
  - RST: line low, counter held.
  - BIT: coding bits.
- Registers: `state`, `cnt[CW-1:0]`, `bitval`, `Dout`, `err`.
- Reset (`reset`=0, asynchronous): `state`=RST, `cnt`=0, `bitval`=0, `Dout`=0, `err`=0. While held in reset, `bdone`=0 and `busy`=0.
- Priority each cycle:
  1. `StartCoding`=1, from any state, including mid-bit: next `state`=BIT, `cnt`=0, next `Dout`=0. `bdone` is suppressed this cycle and any in-flight bit is abandoned.
  2. `state`=RST: hold `cnt`=0, `Dout`=0. `qmode` is ignored.
  3. `state`=BIT, `cnt`=0 (the sample cycle):
     - If `qmode[1]`=1: next `state`=RST, `cnt` stays 0, next `Dout`=0. If `qmode`=11, also set `err`=1.
     - Otherwise: `bitval`←`qmode[0]`, `cnt`←1, next `Dout`=1.
  4. `state`=BIT, 0<`cnt`<`BIT_CLKS`-1: `cnt`←`cnt`+1. Next `Dout` = (`cnt` < TH), where TH=`T1H_CLKS` if `bitval` else `T0H_CLKS`.
  5. `state`=BIT, `cnt`=`BIT_CLKS`-1: `bdone`=1 and `cnt`←0 (wrap). Next `Dout`=0. The next cycle is a sample cycle.
- `bdone` = (`state`=BIT) && (`cnt`=`BIT_CLKS`-1) && !`StartCoding`. It is combinational from registers and `StartCoding` only.
- `busy` = (`state`=BIT).
- `qmode` is sampled only on sample cycles. Changes mid-bit have no effect.
- `err` clears only on reset.
- The RESET low time (> 280 µs) is timed upstream. This block only holds the line low while in RST.

## Timing
- Let S be the cycle in which `StartCoding`=1. Then S+1 is the first sample cycle, and `Dout` rises at the clock edge ending S+1, i.e. `Dout`=1 during S+2.
- `Dout` has a fixed 1-cycle pipeline delay relative to `(state, cnt)`.
- Per coded bit, the `Dout` high width is exactly `T0H_CLKS` or `T1H_CLKS` clocks. The period is exactly `BIT_CLKS` clocks with no gap between consecutive bits.
- `bdone` fires on cycle S+`BIT_CLKS` for the first bit, then every `BIT_CLKS` cycles.
- Upstream drives `qmode` for bit n+1 in the cycle after `bdone`. That cycle is this block's sample cycle, so the shifted bit is used with zero slip.
- End of frame: upstream presents `qmode`=10 in the cycle after the final `bdone`. This block enters RST one cycle later with no high pulse emitted. `busy` falls on that edge.
- Asynchronous reset mid-bit forces `Dout`=0 immediately, not waiting for a clock.

## Test plan
- Single 1 bit:
  - Stimulus: `StartCoding` pulse, `qmode`=01 for one bit, then 10.
  - Required: `Dout` high for 80 clocks then low for 48; one `bdone` at S+128; `state`=RST afterwards with `Dout` held 0.
- Single 0 bit:
  - Stimulus: same as above with `qmode`=00.
  - Required: `Dout` high 40 clocks, low 88; one `bdone`.
- 24-bit frame with a behavioural GRB-machine model:
  - Stimulus: pattern 0xA5_0F_3C.
  - Required: 24 `bdone` pulses spaced 128 clocks apart; decoded `Dout` high widths match the pattern MSB-first; `busy` falls 2 cycles after the 24th `bdone`.
- Restart mid-bit:
  - Stimulus: `StartCoding` at `cnt`=60 of a 1 bit.
  - Required: no `bdone` for the aborted bit; `Dout`=0 for one cycle, then a fresh 80-clock high; next `bdone` 128 clocks after the restart.
- Illegal code:
  - Stimulus: `qmode`=11 on a sample cycle.
  - Required: `state`→RST, `Dout` stays 0, `err`=1 and remains 1 through a later valid frame until reset.
- Asynchronous reset:
  - Stimulus: assert `reset`=0 between clock edges while `Dout`=1.
  - Required: `Dout`, `busy`, `bdone` and `err` all go to 0 without a clock edge. After release, the block idles in RST until `StartCoding`.
